vpifo_task_dispatch: RTL and testbench

- Ingress dispatcher between the per-level TaskFIFOs and the RPU ring of the SRAM vPIFO tree.
- Each cycle it inspects every TaskFIFO head and maps the head's tree to its root slot (tree_id % LEVEL).
- It arbitrates heads that contend for the same slot, and holds issue while the slot is occupied by in-flight ring traffic or the tree is still in cooldown.
- It pops the winning FIFOs and drives registered per-slot push/pop commands into the ring.

---
 rtl/vpifo_pkg.sv | 20 ++
 rtl/vpifo_rr_arbiter.sv | 28 ++
 rtl/vpifo_task_dispatch.sv | 136 +++++++++++++
 tb/tb_vpifo_task_dispatch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vpifo_pkg.sv
// Shared helpers for the vPIFO task dispatcher: tree-to-slot mapping and task width.
package vpifo_pkg;

    typedef enum logic {
        CMD_POP  = 1'b0,
        CMD_PUSH = 1'b1
    } cmd_e;

    // Root slot of a tree on the RPU ring.
    function automatic int unsigned slot_of(input int unsigned tree_id, input int unsigned level);
        return tree_id % level;
    endfunction

    function automatic int unsigned task_width(input int unsigned tree_num,
                                               input int unsigned ptw,
                                               input int unsigned mtw);
        return 1 + $clog2(tree_num) + ptw + mtw;
    endfunction

endpackage

// File: rtl/vpifo_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after the pointer wins.
module vpifo_rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // N is a power of two, so the index wraps by truncation.
    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = i_ptr + PW'(i);
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vpifo_task_dispatch.sv
// Ingress dispatcher: maps TaskFIFO heads to ring slots, arbitrates per slot,
// enforces per-tree cooldown and issues registered push/pop commands.
module vpifo_task_dispatch
    import vpifo_pkg::*;
#(
    parameter  int PTW      = 16,
    parameter  int MTW      = 0,
    parameter  int LEVEL    = 4,
    parameter  int TREE_NUM = 4,
    parameter  int COOLDOWN = 8,
    localparam int TNB      = $clog2(TREE_NUM),
    localparam int TW       = task_width(TREE_NUM, PTW, MTW),
    localparam int DW       = PTW + MTW,
    localparam int CDW      = $clog2(COOLDOWN + 1),
    localparam int LW       = $clog2(LEVEL)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic [TW-1:0]     i_task_data     [0:LEVEL-1],
    input  logic [LEVEL-1:0]  i_task_empty,
    output logic [LEVEL-1:0]  o_task_pop,
    input  logic [LEVEL-1:0]  i_slot_busy,
    output logic [LEVEL-1:0]  o_rpu_push,
    output logic [LEVEL-1:0]  o_rpu_pop,
    output logic [TNB-1:0]    o_rpu_tree_id   [0:LEVEL-1],
    output logic [DW-1:0]     o_rpu_push_data [0:LEVEL-1],
    output logic [15:0]       o_stall_cnt
);

    logic [TNB-1:0]               tree [LEVEL];
    logic [LW-1:0]                slot [LEVEL];
    logic [LEVEL-1:0]             elig;
    logic [LEVEL-1:0][LEVEL-1:0]  req;
    logic [LEVEL-1:0][LEVEL-1:0]  gnt;
    logic [LEVEL-1:0]             task_pop;
    logic                         stall_inc;

    logic [LW-1:0]    rr_q   [LEVEL];
    logic [LW-1:0]    rr_d   [LEVEL];
    logic [CDW-1:0]   cd_q   [TREE_NUM];
    logic [CDW-1:0]   cd_d   [TREE_NUM];
    logic [LEVEL-1:0] push_q, push_d;
    logic [LEVEL-1:0] pop_q, pop_d;
    logic [TNB-1:0]   tid_q  [LEVEL];
    logic [TNB-1:0]   tid_d  [LEVEL];
    logic [DW-1:0]    data_q [LEVEL];
    logic [DW-1:0]    data_d [LEVEL];
    logic [15:0]      stall_q, stall_d;

    // Counter is loaded with COOLDOWN on grant; a value of 1 is its last
    // blocking cycle expiring, so the tree is eligible COOLDOWN cycles after grant.
    always_comb begin
        elig = '0;
        req  = '0;
        for (int f = 0; f < LEVEL; f++) begin
            tree[f] = i_task_data[f][TW-2 -: TNB];
            slot[f] = LW'(slot_of(32'(tree[f]), LEVEL));
            elig[f] = !i_task_empty[f] && !i_slot_busy[slot[f]] && (cd_q[tree[f]] <= CDW'(1));
        end
        for (int s = 0; s < LEVEL; s++) begin
            for (int f = 0; f < LEVEL; f++) begin
                req[s][f] = elig[f] && (slot[f] == LW'(s));
            end
        end
    end

    for (genvar s = 0; s < LEVEL; s++) begin : g_slot
        vpifo_rr_arbiter #(.N(LEVEL)) u_arb (
            .i_req (req[s]),
            .i_ptr (rr_q[s]),
            .o_gnt (gnt[s])
        );
    end

    always_comb begin
        task_pop = '0;
        push_d   = '0;
        pop_d    = '0;
        rr_d     = rr_q;
        for (int s = 0; s < LEVEL; s++) begin
            tid_d[s]  = '0;
            data_d[s] = '1;
        end
        for (int t = 0; t < TREE_NUM; t++) begin
            cd_d[t] = (cd_q[t] != '0) ? cd_q[t] - CDW'(1) : '0;
        end
        for (int s = 0; s < LEVEL; s++) begin
            for (int f = 0; f < LEVEL; f++) begin
                if (gnt[s][f]) begin
                    task_pop[f]   = 1'b1;
                    rr_d[s]       = LW'(f + 1);
                    push_d[s]     = (i_task_data[f][TW-1] == CMD_PUSH);
                    pop_d[s]      = (i_task_data[f][TW-1] == CMD_POP);
                    tid_d[s]      = tree[f];
                    data_d[s]     = push_d[s] ? i_task_data[f][DW-1:0] : '1;
                    cd_d[tree[f]] = CDW'(COOLDOWN);
                end
            end
        end
        stall_inc = |(~i_task_empty & ~task_pop);
        stall_d   = (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            push_q  <= '0;
            pop_q   <= '0;
            stall_q <= '0;
            for (int s = 0; s < LEVEL; s++) begin
                rr_q[s]   <= '0;
                tid_q[s]  <= '0;
                data_q[s] <= '1;
            end
            for (int t = 0; t < TREE_NUM; t++) begin
                cd_q[t] <= '0;
            end
        end else begin
            push_q  <= push_d;
            pop_q   <= pop_d;
            stall_q <= stall_d;
            rr_q    <= rr_d;
            tid_q   <= tid_d;
            data_q  <= data_d;
            cd_q    <= cd_d;
        end
    end

    // Pop strobe is combinational, so gate it directly with reset.
    assign o_task_pop      = task_pop & {LEVEL{i_arst_n}};
    assign o_rpu_push      = push_q;
    assign o_rpu_pop       = pop_q;
    assign o_rpu_tree_id   = tid_q;
    assign o_rpu_push_data = data_q;
    assign o_stall_cnt     = stall_q;

endmodule

// File: tb/tb_vpifo_task_dispatch.sv
// Randomized bench for vpifo_task_dispatch against a queue/timestamp reference model.
module tb_vpifo_task_dispatch;

    localparam int PTW = 16, MTW = 0, LEVEL = 4, TREE_NUM = 8, COOLDOWN = 8;
    localparam int TNB = 3, DW = 16, TW = 1 + TNB + DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [TW-1:0]     task_data [0:LEVEL-1];
    logic [LEVEL-1:0]  task_empty, task_pop, slot_busy, rpu_push, rpu_pop;
    logic [TNB-1:0]    rpu_tid   [0:LEVEL-1];
    logic [DW-1:0]     rpu_data  [0:LEVEL-1];
    logic [15:0]       stall_cnt;

    vpifo_task_dispatch #(
        .PTW(PTW), .MTW(MTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .COOLDOWN(COOLDOWN)
    ) dut (
        .i_clk           (clk),
        .i_arst_n        (rst_n),
        .i_task_data     (task_data),
        .i_task_empty    (task_empty),
        .o_task_pop      (task_pop),
        .i_slot_busy     (slot_busy),
        .o_rpu_push      (rpu_push),
        .o_rpu_pop       (rpu_pop),
        .o_rpu_tree_id   (rpu_tid),
        .o_rpu_push_data (rpu_data),
        .o_stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, RR pointers, per-tree "eligible from" cycle.
    logic [TW-1:0] q [LEVEL][$];
    int            rr [LEVEL];
    int            ready_at [TREE_NUM];
    int            cyc;
    int            m_stall;
    logic          exp_push [LEVEL];
    logic          exp_pop  [LEVEL];
    int            exp_tid  [LEVEL];
    logic [DW-1:0] exp_data [LEVEL];
    int            n_chk = 0;
    int            n_err = 0;
    int            base;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [TW-1:0] mk(input int is_push, input int tree, input int pay);
        logic [TW-1:0] r;
        r = {1'(is_push), 3'(tree), 16'(pay)};
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < LEVEL; s++) begin
            rr[s] = 0;
            exp_push[s] = 1'b0; exp_pop[s] = 1'b0; exp_tid[s] = 0; exp_data[s] = 16'hFFFF;
        end
        for (int t = 0; t < TREE_NUM; t++) ready_at[t] = 0;
        m_stall = 0;
    endtask

    task automatic check_regs(input string pfx);
        for (int s = 0; s < LEVEL; s++) begin
            check_eq($sformatf("%s_push%0d", pfx, s), 32'(rpu_push[s]), 32'(exp_push[s]));
            check_eq($sformatf("%s_pop%0d", pfx, s), 32'(rpu_pop[s]), 32'(exp_pop[s]));
            check_eq($sformatf("%s_tree%0d", pfx, s), 32'(rpu_tid[s]), 32'(exp_tid[s]));
            check_eq($sformatf("%s_data%0d", pfx, s), 32'(rpu_data[s]), 32'(exp_data[s]));
        end
        check_eq($sformatf("%s_stall", pfx), 32'(stall_cnt), 32'(m_stall));
    endtask

    // One clock cycle: check last cycle's commands, drive heads, predict and check pops.
    task automatic step(input logic [LEVEL-1:0] busy);
        int            win [LEVEL];
        int            f, tr;
        logic [TW-1:0] h;
        logic [LEVEL-1:0] want_pop;
        @(negedge clk);
        check_regs("cmd");
        for (int i = 0; i < LEVEL; i++) begin
            if (q[i].size() > 0) begin
                task_data[i]  = q[i][0];
                task_empty[i] = 1'b0;
            end else begin
                task_data[i]  = TW'($urandom);
                task_empty[i] = 1'b1;
            end
        end
        slot_busy = busy;
        #1;
        want_pop = '0;
        for (int s = 0; s < LEVEL; s++) begin
            win[s] = -1;
            for (int k = 0; k < LEVEL; k++) begin
                f = (rr[s] + k) % LEVEL;
                if (win[s] < 0 && q[f].size() > 0) begin
                    h  = q[f][0];
                    tr = int'(h[TW-2 -: TNB]);
                    if (tr % LEVEL == s && !busy[s] && cyc >= ready_at[tr]) win[s] = f;
                end
            end
        end
        for (int s = 0; s < LEVEL; s++) begin
            exp_push[s] = 1'b0; exp_pop[s] = 1'b0; exp_tid[s] = 0; exp_data[s] = 16'hFFFF;
            if (win[s] >= 0) begin
                f  = win[s];
                h  = q[f].pop_front();
                tr = int'(h[TW-2 -: TNB]);
                want_pop[f]  = 1'b1;
                rr[s]        = (f + 1) % LEVEL;
                ready_at[tr] = cyc + COOLDOWN;
                exp_push[s]  = h[TW-1];
                exp_pop[s]   = !h[TW-1];
                exp_tid[s]   = tr;
                exp_data[s]  = h[TW-1] ? h[DW-1:0] : 16'hFFFF;
            end
        end
        if ((|(~task_empty & ~want_pop)) && m_stall < 65535) m_stall++;
        check_eq("task_pop", 32'(task_pop), 32'(want_pop));
        cyc++;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        task_empty = '1;
        slot_busy  = '0;
        for (int i = 0; i < LEVEL; i++) task_data[i] = '0;
        cyc = 0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_regs("rst");
        check_eq("rst_pop", 32'(task_pop), 32'h0);
        #1 rst_n = 1'b1;

        // Idle after reset
        repeat (20) step('0);

        // Single uncontended push
        q[0].push_back(mk(1, 1, 'h0042));
        repeat (3) step('0);

        // Same tree in two FIFOs: loser waits out the cooldown
        q[0].push_back(mk(1, 2, 'h0010));
        q[2].push_back(mk(0, 2, 'h1234));
        base = m_stall;
        repeat (12) step('0);
        after_edge();
        check_eq("t3_stall", 32'(stall_cnt), 32'(base + 8));

        // Two trees sharing slot 3: RR alternation
        for (int i = 0; i < 3; i++) begin
            q[1].push_back(mk(1, 3, 'h300 + i));
            q[3].push_back(mk(0, 7, 'h700 + i));
        end
        repeat (30) step('0);

        // All four slots in the same cycle
        q[0].push_back(mk(1, 4, 'hA004));
        q[1].push_back(mk(1, 5, 'hA005));
        q[2].push_back(mk(0, 6, 'hA006));
        q[3].push_back(mk(1, 3, 'hA003));
        step('0);
        check_eq("t4_parallel", 32'(task_pop), 32'hF);
        repeat (10) step('0);

        // Busy slot holds the FIFO
        q[0].push_back(mk(1, 2, 'h0077));
        base = m_stall;
        repeat (5) step(4'b0100);
        after_edge();
        check_eq("t5_stall", 32'(stall_cnt), 32'(base + 5));
        step('0);
        check_eq("t5_issue", 32'(task_pop[0]), 32'h1);
        repeat (10) step('0);

        // Reset right after a grant
        q[0].push_back(mk(1, 1, 'h00A1));
        q[0].push_back(mk(1, 1, 'h00A2));
        step('0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        task_data[0]  = q[0][0];
        task_empty[0] = 1'b0;
        #1;
        check_regs("t6_rst");
        check_eq("t6_rst_pop", 32'(task_pop), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step('0);
        check_eq("t6_reissue", 32'(task_pop[0]), 32'h1);
        repeat (3) step('0);

        // Randomized traffic
        repeat (400) begin
            for (int i = 0; i < LEVEL; i++) begin
                if (q[i].size() < 4 && $urandom_range(0, 2) == 0)
                    q[i].push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 65535))));
            end
            step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        repeat (40) step('0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
